// File: rtl/ps2_host_tx_if.sv
// CPU-side command port of the PS/2 host transmitter: byte + strobe in,
// busy/done/error status out.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output tx_data,
        output tx_start,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-bit frame, ACK.
// Optional macro PS2_TX_ACK_CHECK_EN: a NACK (ACK sample of 1) also raises error.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYC = 5000,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic          clk,
    input  logic          rst_n,
    ps2_host_tx_if.slave  host,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);

    localparam int unsigned CMAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    sr_q, sr_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic clk_s1_q, clk_s2_q, clk_s3_q;
    logic dat_s1_q, dat_s2_q;
    logic clk_fall;

    logic clk_oe, data_oe, busy, done, watch;

    // Synchronizers idle high so reset never fakes a clock falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            clk_s3_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk_in;
            clk_s2_q <= clk_s1_q;
            clk_s3_q <= clk_s2_q;
            dat_s1_q <= ps2_data_in;
            dat_s2_q <= dat_s1_q;
        end
    end

    assign clk_fall = clk_s3_q & ~clk_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        clk_oe  = 1'b0;
        data_oe = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        watch   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (host.tx_start) begin
                    sr_d    = {1'b1, ~^host.tx_data, host.tx_data};
                    bit_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                busy   = 1'b1;
                clk_oe = 1'b1;
                if (cnt_q == INH_LAST) begin
                    data_oe = 1'b1;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REQ: begin
                busy    = 1'b1;
                data_oe = 1'b1;
                watch   = 1'b1;
                if (clk_fall) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy    = 1'b1;
                data_oe = ~sr_q[0];
                watch   = 1'b1;
                if (clk_fall) begin
                    sr_d  = {1'b0, sr_q[9:1]};
                    bit_d = bit_q + 4'd1;
                    // bit_q reaching 9 means the stop bit is now on the line
                    if (bit_q == 4'd8) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                busy  = 1'b1;
                watch = 1'b1;
                if (clk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                    err_d = err_q | dat_s2_q;
`else
                    err_d = err_q;
`endif
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                busy  = 1'b1;
                watch = 1'b1;
                if (clk_s2_q && dat_s2_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shared watchdog: restarts on every device clock fall, aborts the
        // transfer if the device stalls too long in any device-paced state.
        if (watch) begin
            if (clk_fall) begin
                cnt_d = '0;
            end else if (cnt_q == TMO_LAST) begin
                err_d   = 1'b1;
                state_d = S_DONE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign ps2_clk_oe  = clk_oe;
    assign ps2_data_oe = data_oe;
    assign host.busy   = busy;
    assign host.done   = done;
    assign host.error  = err_q;

endmodule
